// File: rtl/riscpipe_pkg.sv
// Shared definitions for the IITB RISC pipeline: the memory-access word layout,
// the op encodings it carries, and the memory/write-back stage state encoding.
package riscpipe_pkg;

    localparam int MA_W          = 37;
    localparam int MA_SDATA_LSB  = 21;
    localparam int MA_RES_LSB    = 5;
    localparam int MA_RD_LSB     = 2;
    localparam int MA_OP_LSB     = 0;

    typedef enum logic [1:0] {
        MA_NOP = 2'b00,
        MA_ALU = 2'b01,
        MA_LD  = 2'b10,
        MA_ST  = 2'b11
    } ma_op_e;

    // Field order matches the bit positions above, so a plain cast unpacks the word.
    typedef struct packed {
        logic [15:0] sdata;
        logic [15:0] res;
        logic [2:0]  rd;
        ma_op_e      op;
    } ma_word_t;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_WB       = 2'd2
    } ma_state_e;

    function automatic logic is_mem_op(input ma_op_e op);
        return (op == MA_LD) || (op == MA_ST);
    endfunction

endpackage

// File: rtl/mem_handshake.sv
// Data-memory req/ack driver: holds the request and its address/data stable until
// ack, and abandons the access after TIMEOUT cycles without one.
module mem_handshake #(
    parameter int TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        start_i,
    input  logic        we_i,
    input  logic [15:0] addr_i,
    input  logic [15:0] wdata_i,
    input  logic        ack_i,
    output logic        req_o,
    output logic        we_o,
    output logic [15:0] addr_o,
    output logic [15:0] wdata_o,
    output logic        done_o,
    output logic        timeout_o
);

    localparam logic [7:0] CNT_MAX  = 8'(TIMEOUT);
    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    logic        req_q, we_q;
    logic [15:0] addr_q, wdata_q;
    logic [7:0]  cnt_q, cnt_d;

    // An ack in the expiry cycle still completes the access.
    assign done_o    = req_q & ack_i;
    assign timeout_o = req_q & ~ack_i & (cnt_q == CNT_LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (start_i || done_o || timeout_o || !req_q)
            cnt_d = 8'd0;
        else if (cnt_q != CNT_MAX)
            cnt_d = cnt_q + 8'd1;
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= 16'd0;
            wdata_q <= 16'd0;
            cnt_q   <= 8'd0;
        end else begin
            cnt_q <= cnt_d;
            if (start_i) begin
                req_q   <= 1'b1;
                we_q    <= we_i;
                addr_q  <= addr_i;
                wdata_q <= wdata_i;
            end else if (done_o || timeout_o) begin
                req_q <= 1'b0;
            end
        end
    end

    assign req_o   = req_q;
    assign we_o    = we_q;
    assign addr_o  = addr_q;
    assign wdata_o = wdata_q;

endmodule

// File: rtl/mem_access_wb.sv
// Memory-access / write-back stage: runs loads and stores through mem_handshake,
// writes ALU or load results to the register file and exposes a forwarding tap.
module mem_access_wb
    import riscpipe_pkg::*;
#(
    parameter int TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        flush,
    input  logic        ma_valid,
    input  logic [36:0] ma_data,
    output logic        ma_ready,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [15:0] dmem_addr,
    output logic [15:0] dmem_wdata,
    input  logic        dmem_ack,
    input  logic [15:0] dmem_rdata,
    output logic        rf_we,
    output logic [2:0]  rf_waddr,
    output logic [15:0] rf_wdata,
    output logic        fwd_valid,
    output logic [2:0]  fwd_reg,
    output logic [15:0] fwd_data,
    output logic        err
);

    ma_word_t    in_w;
    ma_state_e   state_q;
    logic [2:0]  rd_q;
    logic [15:0] res_q;
    logic        kill_q, err_q;
    logic        accept, start_mem, wb_fire, hs_done, hs_timeout;

    assign in_w      = ma_word_t'(ma_data);
    assign ma_ready  = (state_q != ST_MEM_WAIT);
    assign accept    = ma_valid & ma_ready & ~flush;
    assign start_mem = accept & is_mem_op(in_w.op);
    // Flush in the write-back cycle squashes both the pending write and any new transfer.
    assign wb_fire   = (state_q == ST_WB) & ~kill_q & ~flush;

    mem_handshake #(.TIMEOUT(TIMEOUT)) u_hs (
        .clk       (clk),
        .resetn    (resetn),
        .start_i   (start_mem),
        .we_i      (in_w.op[0]),
        .addr_i    (in_w.res),
        .wdata_i   (in_w.sdata),
        .ack_i     (dmem_ack),
        .req_o     (dmem_req),
        .we_o      (dmem_we),
        .addr_o    (dmem_addr),
        .wdata_o   (dmem_wdata),
        .done_o    (hs_done),
        .timeout_o (hs_timeout)
    );

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= ST_IDLE;
            rd_q    <= 3'd0;
            res_q   <= 16'd0;
            kill_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE, ST_WB: begin
                    state_q <= ST_IDLE;
                    if (accept) begin
                        case (in_w.op)
                            MA_ALU: begin
                                state_q <= ST_WB;
                                rd_q    <= in_w.rd;
                                res_q   <= in_w.res;
                                kill_q  <= 1'b0;
                            end
                            MA_LD, MA_ST: begin
                                state_q <= ST_MEM_WAIT;
                                rd_q    <= in_w.rd;
                                kill_q  <= 1'b0;
                            end
                            default: state_q <= ST_IDLE;
                        endcase
                    end
                end
                ST_MEM_WAIT: begin
                    // The bus access runs to completion; flush only cancels its write-back.
                    if (flush)
                        kill_q <= 1'b1;
                    if (hs_done) begin
                        if (!dmem_we) begin
                            state_q <= ST_WB;
                            res_q   <= dmem_rdata;
                        end else begin
                            state_q <= ST_IDLE;
                        end
                    end else if (hs_timeout) begin
                        state_q <= ST_IDLE;
                        err_q   <= 1'b1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign rf_we     = wb_fire;
    assign rf_waddr  = rd_q;
    assign rf_wdata  = res_q;
    assign fwd_valid = wb_fire;
    assign fwd_reg   = rd_q;
    assign fwd_data  = res_q;
    assign err       = err_q;

endmodule

// File: tb/tb_mem_access_wb.sv
// Directed bench for mem_access_wb: a per-cycle vector table for the main flows
// plus hand-written timeout and reset-during-access sequences.
module tb_mem_access_wb;

    logic        clk = 1'b0;
    logic        resetn, flush, ma_valid, dmem_ack;
    logic [36:0] ma_data;
    logic [15:0] dmem_rdata;
    logic        ma_ready, dmem_req, dmem_we, rf_we, fwd_valid, err;
    logic [15:0] dmem_addr, dmem_wdata, rf_wdata, fwd_data;
    logic [2:0]  rf_waddr, fwd_reg;

    int errors = 0;
    int checks = 0;

    mem_access_wb #(.TIMEOUT(15)) dut (
        .clk(clk), .resetn(resetn), .flush(flush),
        .ma_valid(ma_valid), .ma_data(ma_data), .ma_ready(ma_ready),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .fwd_valid(fwd_valid), .fwd_reg(fwd_reg), .fwd_data(fwd_data),
        .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        v, f, ack;
        logic [36:0] d;
        logic [15:0] rdata;
        logic        rdy, rfwe, req, we, fwd, err;
        logic [2:0]  wa;
        logic [15:0] wd, addr, mwd;
    } vec_t;

    vec_t tv[$];

    function automatic logic [36:0] mk(input logic [1:0] op, input logic [2:0] rd,
                                       input logic [15:0] res, input logic [15:0] sd);
        return {sd, res, rd, op};
    endfunction

    function automatic vec_t V(input logic v, f, input logic [36:0] d, input logic ack,
                               input logic [15:0] rdata, input logic rdy, rfwe,
                               input logic [2:0] wa, input logic [15:0] wd,
                               input logic req, we, input logic [15:0] addr, mwd,
                               input logic fwd, e);
        vec_t x;
        x.v = v; x.f = f; x.d = d; x.ack = ack; x.rdata = rdata;
        x.rdy = rdy; x.rfwe = rfwe; x.wa = wa; x.wd = wd;
        x.req = req; x.we = we; x.addr = addr; x.mwd = mwd; x.fwd = fwd; x.err = e;
        return x;
    endfunction

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic v, f, input logic [36:0] d, input logic ack,
                         input logic [15:0] rdata);
        @(negedge clk);
        ma_valid = v; flush = f; ma_data = d; dmem_ack = ack; dmem_rdata = rdata;
        #1;
    endtask

    task automatic apply(input int i, input vec_t x);
        drive(x.v, x.f, x.d, x.ack, x.rdata);
        chk($sformatf("v%0d ma_ready", i), 16'(ma_ready), 16'(x.rdy));
        chk($sformatf("v%0d rf_we", i), 16'(rf_we), 16'(x.rfwe));
        chk($sformatf("v%0d fwd_valid", i), 16'(fwd_valid), 16'(x.fwd));
        chk($sformatf("v%0d dmem_req", i), 16'(dmem_req), 16'(x.req));
        chk($sformatf("v%0d err", i), 16'(err), 16'(x.err));
        if (x.rfwe) begin
            chk($sformatf("v%0d rf_waddr", i), 16'(rf_waddr), 16'(x.wa));
            chk($sformatf("v%0d rf_wdata", i), rf_wdata, x.wd);
        end
        if (x.fwd) begin
            chk($sformatf("v%0d fwd_reg", i), 16'(fwd_reg), 16'(x.wa));
            chk($sformatf("v%0d fwd_data", i), fwd_data, x.wd);
        end
        if (x.req) begin
            chk($sformatf("v%0d dmem_we", i), 16'(dmem_we), 16'(x.we));
            chk($sformatf("v%0d dmem_addr", i), dmem_addr, x.addr);
            if (x.we) chk($sformatf("v%0d dmem_wdata", i), dmem_wdata, x.mwd);
        end
    endtask

    initial begin
        int n;
        resetn = 1'b0; flush = 1'b0; ma_valid = 1'b0; ma_data = '0;
        dmem_ack = 1'b0; dmem_rdata = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        resetn = 1'b1;
        #1;
        chk("reset ma_ready", 16'(ma_ready), 16'd1);
        chk("reset dmem_req", 16'(dmem_req), 16'd0);
        chk("reset rf_we", 16'(rf_we), 16'd0);
        chk("reset fwd_valid", 16'(fwd_valid), 16'd0);
        chk("reset err", 16'(err), 16'd0);

        //          v  f  data                         ack rdata    rdy we wa  wd       req we addr     mwd      fwd err
        // back-to-back ALU write-backs
        tv.push_back(V(1, 0, mk(2'b01, 3, 16'h1234, 0), 0, 0,       1, 0, 0, 0,       0, 0, 0,       0,       0, 0));
        tv.push_back(V(1, 0, mk(2'b01, 5, 16'hFFFF, 0), 0, 0,       1, 1, 3, 16'h1234, 0, 0, 0,      0,       1, 0));
        tv.push_back(V(1, 0, mk(2'b01, 0, 16'h0001, 0), 0, 0,       1, 1, 5, 16'hFFFF, 0, 0, 0,      0,       1, 0));
        tv.push_back(V(0, 0, 0,                         0, 0,       1, 1, 0, 16'h0001, 0, 0, 0,      0,       1, 0));
        tv.push_back(V(0, 0, 0,                         0, 0,       1, 0, 0, 0,       0, 0, 0,       0,       0, 0));
        // load R2 from 0x0040, ack on third wait cycle
        tv.push_back(V(1, 0, mk(2'b10, 2, 16'h0040, 0), 0, 0,       1, 0, 0, 0,       0, 0, 0,       0,       0, 0));
        tv.push_back(V(0, 0, 0,                         0, 0,       0, 0, 0, 0,       1, 0, 16'h0040, 0,      0, 0));
        tv.push_back(V(0, 0, 0,                         0, 0,       0, 0, 0, 0,       1, 0, 16'h0040, 0,      0, 0));
        tv.push_back(V(0, 0, 0,                         1, 16'hBEEF, 0, 0, 0, 0,      1, 0, 16'h0040, 0,      0, 0));
        tv.push_back(V(0, 0, 0,                         0, 0,       1, 1, 2, 16'hBEEF, 0, 0, 0,      0,       1, 0));
        // store 0xA5A5 to 0x0010, ack on first wait cycle
        tv.push_back(V(1, 0, mk(2'b11, 0, 16'h0010, 16'hA5A5), 0, 0, 1, 0, 0, 0,     0, 0, 0,       0,       0, 0));
        tv.push_back(V(0, 0, 0,                         1, 0,       0, 0, 0, 0,       1, 1, 16'h0010, 16'hA5A5, 0, 0));
        // flushed ALU transfer in IDLE is dropped
        tv.push_back(V(1, 1, mk(2'b01, 1, 16'h9999, 0), 0, 0,       1, 0, 0, 0,       0, 0, 0,       0,       0, 0));
        tv.push_back(V(1, 0, mk(2'b00, 1, 16'h8888, 0), 0, 0,       1, 0, 0, 0,       0, 0, 0,       0,       0, 0));
        // nop leaves nothing behind; then ALU squashed by flush in its WB cycle
        tv.push_back(V(1, 0, mk(2'b01, 4, 16'h5555, 0), 0, 0,       1, 0, 0, 0,       0, 0, 0,       0,       0, 0));
        tv.push_back(V(0, 1, 0,                         0, 0,       1, 0, 0, 0,       0, 0, 0,       0,       0, 0));
        // load R6 with flush during wait: bus completes, no write-back
        tv.push_back(V(1, 0, mk(2'b10, 6, 16'h0080, 0), 0, 0,       1, 0, 0, 0,       0, 0, 0,       0,       0, 0));
        tv.push_back(V(0, 1, 0,                         0, 0,       0, 0, 0, 0,       1, 0, 16'h0080, 0,      0, 0));
        tv.push_back(V(0, 0, 0,                         1, 16'h1111, 0, 0, 0, 0,      1, 0, 16'h0080, 0,      0, 0));
        tv.push_back(V(0, 0, 0,                         0, 0,       1, 0, 0, 0,       0, 0, 0,       0,       0, 0));
        tv.push_back(V(0, 0, 0,                         0, 0,       1, 0, 0, 0,       0, 0, 0,       0,       0, 0));

        foreach (tv[i]) apply(i, tv[i]);

        // Timeout: load with no ack
        drive(1, 0, mk(2'b10, 1, 16'h0100, 0), 0, 0);
        n = 0;
        for (int c = 0; c < 40; c++) begin
            drive(0, 0, 0, 0, 0);
            if (!dmem_req) break;
            if (err) begin
                errors++;
                $display("FAIL timeout early err: got 1 want 0 at cycle %0d", c);
            end
            n++;
        end
        chk("timeout req cycles", 16'(n), 16'd15);
        chk("timeout err set", 16'(err), 16'd1);
        chk("timeout ma_ready", 16'(ma_ready), 16'd1);
        chk("timeout no rf_we", 16'(rf_we), 16'd0);
        drive(1, 0, mk(2'b01, 7, 16'h7777, 0), 0, 0);
        drive(0, 0, 0, 0, 0);
        chk("post-timeout rf_we", 16'(rf_we), 16'd1);
        chk("post-timeout rf_waddr", 16'(rf_waddr), 16'd7);
        chk("post-timeout rf_wdata", rf_wdata, 16'h7777);
        chk("err sticky", 16'(err), 16'd1);

        // Ack in the expiry cycle wins over the timeout
        drive(1, 0, mk(2'b10, 3, 16'h0200, 0), 0, 0);
        repeat (14) drive(0, 0, 0, 0, 0);
        drive(0, 0, 0, 1, 16'h2222);
        chk("late-ack req still high", 16'(dmem_req), 16'd1);
        drive(0, 0, 0, 0, 0);
        chk("late-ack rf_we", 16'(rf_we), 16'd1);
        chk("late-ack rf_waddr", 16'(rf_waddr), 16'd3);
        chk("late-ack rf_wdata", rf_wdata, 16'h2222);

        // Reset during MEM_WAIT; the ack arriving afterwards must be ignored
        drive(1, 0, mk(2'b10, 5, 16'h0300, 0), 0, 0);
        drive(0, 0, 0, 0, 0);
        chk("pre-reset req", 16'(dmem_req), 16'd1);
        @(negedge clk);
        resetn = 1'b0;
        drive(0, 0, 0, 1, 16'h3333);
        resetn = 1'b1;
        #1;
        chk("rst req dropped", 16'(dmem_req), 16'd0);
        chk("rst rf_we", 16'(rf_we), 16'd0);
        chk("rst ma_ready", 16'(ma_ready), 16'd1);
        chk("rst err cleared", 16'(err), 16'd0);
        drive(0, 0, 0, 0, 0);
        chk("rst no late wb", 16'(rf_we), 16'd0);
        chk("rst no late fwd", 16'(fwd_valid), 16'd0);
        chk("rst still idle", 16'(dmem_req), 16'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
